// File: rtl/mp_add_pkg.sv
// Shared types for the multi-precision add sequencer: packet state and
// the operand-stage record presented to the external adder.
package mp_add_pkg;

  localparam int WORD_W_DEF = 32;

  typedef enum logic {
    FIRST = 1'b0,
    BODY  = 1'b1
  } pkt_state_t;

  typedef struct packed {
    logic [WORD_W_DEF-1:0] a;
    logic [WORD_W_DEF-1:0] b;
    logic                  first;
    logic                  last;
  } op_stage_t;

endpackage

// File: rtl/mp_add_out_reg.sv
// Result stage of the sequencer: a single valid/ready register holding the
// sum word, last flag and packet carry-out until downstream accepts it.
module mp_add_out_reg
  import mp_add_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] d_sum,
  input  logic              d_last,
  input  logic              d_cout,
  input  logic              out_ready,
  output logic              adv,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_cout
);

  logic              valid_reg;
  logic [WORD_W-1:0] sum_reg;
  logic              last_reg;
  logic              cout_reg;

  assign adv       = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_sum   = sum_reg;
  assign out_last  = last_reg;
  assign out_cout  = cout_reg;

  // load is only raised by the caller when adv is high, so data never
  // changes underneath a stalled result word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      sum_reg   <= '0;
      last_reg  <= 1'b0;
      cout_reg  <= 1'b0;
    end else begin
      if (adv) begin
        valid_reg <= load;
      end
      if (load) begin
        sum_reg  <= d_sum;
        last_reg <= d_last;
        cout_reg <= d_cout;
      end
    end
  end

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision add sequencer: feeds an external 32-bit adder word by word
// (LSW first), chains the carry, and streams the sum words back out.
// Optional subtract mode is enabled by defining MP_ADD_SUB_EN.
module mp_add_sequencer
  import mp_add_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int MAX_WORDS = 4,
  parameter int CNT_W     = $clog2(MAX_WORDS) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_cin,
  input  logic              in_last,
`ifdef MP_ADD_SUB_EN
  input  logic              in_sub,
`endif
  output logic [WORD_W-1:0] add_a,
  output logic [WORD_W-1:0] add_b,
  output logic              add_cin,
  input  logic [WORD_W-1:0] add_sum,
  input  logic              add_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_cout,
  output logic              err_len
);

  pkt_state_t       state_reg, state_next;
  op_stage_t        op_reg;
  logic             op_valid_reg;
  logic             op_cin_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             err_len_reg;
`ifdef MP_ADD_SUB_EN
  logic             sub_reg;
`endif

  logic             adv1, adv2, accept;
  logic [CNT_W-1:0] word_num;
  logic             at_max, force_last;
  logic             word_sub, word_cin;

  assign in_ready = !op_valid_reg || adv2;
  assign accept   = in_valid && in_ready;
  assign adv1     = op_valid_reg && adv2;

  assign add_a   = op_reg.a;
  assign add_b   = op_reg.b;
  assign add_cin = op_reg.first ? op_cin_reg : carry_reg;
  assign err_len = err_len_reg;

`ifdef MP_ADD_SUB_EN
  assign word_sub = (state_reg == FIRST) ? in_sub : sub_reg;
  assign word_cin = in_sub ? 1'b1 : in_cin;
`else
  assign word_sub = 1'b0;
  assign word_cin = in_cin;
`endif

  always_comb begin
    state_next = state_reg;
    word_num   = (state_reg == FIRST) ? CNT_W'(1) : cnt_reg + CNT_W'(1);
    at_max     = (word_num == CNT_W'(MAX_WORDS));
    force_last = at_max && !in_last;
    if (accept) begin
      state_next = (in_last || at_max) ? FIRST : BODY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FIRST;
    end else begin
      state_reg <= state_next;
    end
  end

  // Stage 1. The carry is captured on the same edge the next word enters,
  // so consecutive words of a packet flow without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg       <= '0;
      op_valid_reg <= 1'b0;
      op_cin_reg   <= 1'b0;
      carry_reg    <= 1'b0;
      cnt_reg      <= '0;
      err_len_reg  <= 1'b0;
`ifdef MP_ADD_SUB_EN
      sub_reg      <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_reg.a     <= in_a;
        op_reg.b     <= word_sub ? ~in_b : in_b;
        op_reg.first <= (state_reg == FIRST);
        op_reg.last  <= in_last || at_max;
        op_valid_reg <= 1'b1;
        cnt_reg      <= word_num;
        if (state_reg == FIRST) begin
          op_cin_reg <= word_cin;
`ifdef MP_ADD_SUB_EN
          sub_reg    <= in_sub;
`endif
        end
        if (force_last) begin
          err_len_reg <= 1'b1;
        end
      end else if (adv1) begin
        op_valid_reg <= 1'b0;
      end
      if (adv1) begin
        carry_reg <= op_reg.last ? 1'b0 : add_cout;
      end
    end
  end

  mp_add_out_reg #(
    .WORD_W(WORD_W)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (adv1),
    .d_sum    (add_sum),
    .d_last   (op_reg.last),
    .d_cout   (op_reg.last && add_cout),
    .out_ready(out_ready),
    .adv      (adv2),
    .out_valid(out_valid),
    .out_sum  (out_sum),
    .out_last (out_last),
    .out_cout (out_cout)
  );

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Self-checking bench for mp_add_sequencer: table vectors, directed corner
// sequences and randomized packets checked against a wide-add reference.
`timescale 1ns/1ps
module tb_mp_add_sequencer;
  localparam int W    = 32;
  localparam int MAXW = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_last = 1'b0;
`ifdef MP_ADD_SUB_EN
  logic         in_sub = 1'b0;
`endif
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_last, out_cout, err_len;

  always #5 clk = ~clk;

  // External combinational adder stage
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  mp_add_sequencer #(.WORD_W(W), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_last(in_last),
`ifdef MP_ADD_SUB_EN
    .in_sub(in_sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_last(out_last), .out_cout(out_cout), .err_len(err_len)
  );

  logic acc_q = 1'b0;
  always @(posedge clk) acc_q <= in_valid && in_ready;

  typedef struct {
    logic [W-1:0] sum;
    logic         last;
    logic         cout;
  } exp_t;

  typedef struct {
    int           n;
    logic [127:0] a;
    logic [127:0] b;
    logic         cin;
    logic [127:0] sum;
    logic         cout;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[7];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic rand_rdy = 1'b0;
  logic mon_en = 1'b1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference: the whole packet as one wide addition, then sliced into words.
  task automatic push_pkt(input int n, input logic [127:0] wa, input logic [127:0] wb, input logic cin);
    logic [159:0] ws;
    exp_t e;
    ws = {32'b0, wa} + {32'b0, wb} + {159'b0, cin};
    for (int i = 0; i < n; i++) begin
      e.sum  = ws[i*32 +: 32];
      e.last = (i == n - 1);
      e.cout = (i == n - 1) ? ws[n*32] : 1'b0;
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    return ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : W'($urandom);
  endfunction

  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic last);
    int budget;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_last = last;
    budget = 0;
    do begin
      @(posedge clk); #1;
      budget++;
    end while (!acc_q && budget < 1000);
    if (!acc_q) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: in_ready never rose for word %h", a);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d result words missing, required 0", exp_q.size());
    end
  endtask

  task automatic mon_loop();
    logic         stalled;
    logic [W-1:0] h_sum;
    logic         h_last, h_cout;
    exp_t         e;
    stalled = 1'b0; h_sum = '0; h_last = 1'b0; h_cout = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          n_cmp++;
          if (!out_valid || out_sum !== h_sum || out_last !== h_last || out_cout !== h_cout) begin
            n_fail++;
            $display("FAIL stall_hold: got v=%b sum=%h last=%b cout=%b required v=1 sum=%h last=%b cout=%b",
                     out_valid, out_sum, out_last, out_cout, h_sum, h_last, h_cout);
          end
        end
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_valid && out_ready && mon_en) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_word: got sum=%h with no word outstanding", out_sum);
          end else begin
            e = exp_q.pop_front();
            if (out_sum !== e.sum || out_last !== e.last || out_cout !== e.cout) begin
              n_fail++;
              $display("FAIL result_word: got sum=%h last=%b cout=%b required sum=%h last=%b cout=%b",
                       out_sum, out_last, out_cout, e.sum, e.last, e.cout);
            end
          end
        end
        stalled = out_valid && !out_ready;
        h_sum = out_sum; h_last = out_last; h_cout = out_cout;
      end
    end
  endtask

  int           n;
  logic [127:0] wa, wb;
  logic [159:0] xa, xb;
  logic         cin;

  initial begin
    tbl[0] = '{2, 128'h00000001_FFFFFFFF, 128'h1, 1'b0, 128'h00000002_00000000, 1'b0};
    tbl[1] = '{1, 128'hFFFFFFFF, 128'h1, 1'b0, 128'h0, 1'b1};
    tbl[2] = '{1, 128'h5, 128'h3, 1'b0, 128'h8, 1'b0};
    tbl[3] = '{3, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 128'h0, 1'b1};
    tbl[4] = '{4, {128{1'b1}}, 128'h0, 1'b1, 128'h0, 1'b1};
    tbl[5] = '{1, 128'h7, 128'h8, 1'b1, 128'h10, 1'b0};
    tbl[6] = '{2, 128'hFFFFFFFF_00000000, 128'h00000001_00000000, 1'b0, 128'h0, 1'b1};

    fork
      mon_loop();
    join_none

    // Reset state
    #1;
    chk("rst_add_a", add_a, '0);
    chk("rst_add_b", add_b, '0);
    chk("rst_add_cin", W'(add_cin), '0);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_out_sum", out_sum, '0);
    chk("rst_err_len", W'(err_len), '0);
    chk("rst_in_ready", W'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single word with carry-out: latency of two edges
    exp_q.push_back('{32'h0, 1'b1, 1'b1});
    send_word(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
    chk("lat_not_yet_valid", W'(out_valid), '0);
    @(posedge clk); #1;
    chk("lat_valid", W'(out_valid), 32'd1);
    chk("lat_sum", out_sum, 32'h0);
    chk("lat_last", W'(out_last), 32'd1);
    chk("lat_cout", W'(out_cout), 32'd1);
    drain();

    // Table vectors, issued back to back
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < tbl[t].n; i++) begin
        exp_q.push_back('{tbl[t].sum[i*32 +: 32], (i == tbl[t].n - 1),
                          (i == tbl[t].n - 1) ? tbl[t].cout : 1'b0});
      end
      for (int i = 0; i < tbl[t].n; i++) begin
        send_word(tbl[t].a[i*32 +: 32], tbl[t].b[i*32 +: 32], tbl[t].cin, (i == tbl[t].n - 1));
      end
    end
    drain();

    // Randomized packets with downstream back-pressure
    rand_rdy = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      n = $urandom_range(1, 4);
      wa = '0; wb = '0;
      cin = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        wa[i*32 +: 32] = rnd_word();
        wb[i*32 +: 32] = rnd_word();
      end
      push_pkt(n, wa, wb, cin);
      for (int i = 0; i < n; i++) begin
        send_word(wa[i*32 +: 32], wb[i*32 +: 32], cin, (i == n - 1));
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();
    rand_rdy = 1'b0;
    chk("err_len_before_ovf", W'(err_len), '0);

    // Five words with no last until the fifth: split at MAX_WORDS
    xa = {32'h5, {128{1'b1}}};
    xb = {32'h3, 128'h1};
    push_pkt(4, xa[127:0], xb[127:0], 1'b0);
    push_pkt(1, {96'b0, xa[159:128]}, {96'b0, xb[159:128]}, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send_word(xa[i*32 +: 32], xb[i*32 +: 32], (i == 4), (i == 4));
      if (i == 3) begin
        chk("err_len_on_ovf", W'(err_len), 32'd1);
      end
    end
    drain();
    chk("err_len_sticky", W'(err_len), 32'd1);

`ifdef MP_ADD_SUB_EN
    in_sub = 1'b1;
    exp_q.push_back('{32'hFFFF_FFFE, 1'b1, 1'b0});
    send_word(32'h3, 32'h5, 1'b0, 1'b1);
    in_sub = 1'b0;
    drain();
`endif

    // Reset in the middle of a packet
    mon_en = 1'b0;
    send_word(32'h1, 32'h1, 1'b0, 1'b0);
    send_word(32'h2, 32'h2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_add_a", add_a, '0);
    chk("midrst_add_b", add_b, '0);
    chk("midrst_add_cin", W'(add_cin), '0);
    chk("midrst_out_valid", W'(out_valid), '0);
    chk("midrst_out_sum", out_sum, '0);
    chk("midrst_out_last", W'(out_last), '0);
    chk("midrst_out_cout", W'(out_cout), '0);
    chk("midrst_err_len", W'(err_len), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    // First word after reset must sample in_cin: 1 + 1 + 1 = 3
    exp_q.push_back('{32'h3, 1'b1, 1'b0});
    send_word(32'h1, 32'h1, 1'b1, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
